// File: rtl/lectura_operandos.sv
// Operand fetch for the 2R/1W register file: issues reads on accept, forwards
// writes the synchronous read path misses, and presents both operands to
// execute under a valid/ready handshake with a one-entry hold on stall.
module lectura_operandos #(
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             rf_hab_r1,
    output logic [4:0]       rf_addr_r1,
    input  logic [31:0]      rf_data_r1,
    output logic             rf_hab_r2,
    output logic [4:0]       rf_addr_r2,
    input  logic [31:0]      rf_data_r2,
    input  logic             wb_hab,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_op1,
    output logic [31:0]      out_op2,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {VACIO, LECTURA, RETENIDO} state_t;

    state_t state_q, state_d;

    logic [4:0]       rs1_q, rs2_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      byp1_q, byp2_q;
    logic             bypf1_q, bypf2_q;
    logic [31:0]      hold1_q, hold2_q;

    logic        acc, xfer;
    logic [31:0] lect_op1, lect_op2;

    // A write-port transaction that must be reflected in an operand read from rs.
    // x0 never forwards.
    function automatic logic fwd_hit(input logic hab, input logic [4:0] wa,
                                     input logic [4:0] rs);
        return hab && (wa != 5'd0) && (wa == rs);
    endfunction

    assign out_valid  = (state_q != VACIO);
    assign xfer       = out_valid && out_ready;
    assign in_ready   = !rst && ((state_q == VACIO) || xfer);
    assign acc        = in_valid && in_ready;

    assign rf_hab_r1  = acc;
    assign rf_hab_r2  = acc;
    assign rf_addr_r1 = in_rs1;
    assign rf_addr_r2 = in_rs2;

    // Operand seen in the cycle right after issue: x0 forced to zero, an
    // issue-cycle write overrides the stale read data.
    assign lect_op1 = (rs1_q == 5'd0) ? 32'd0 : (bypf1_q ? byp1_q : rf_data_r1);
    assign lect_op2 = (rs2_q == 5'd0) ? 32'd0 : (bypf2_q ? byp2_q : rf_data_r2);

    // Only LECTURA exposes the live read path; otherwise the registered hold
    // copy is shown (zero after reset).
    assign out_op1 = (state_q == LECTURA) ? lect_op1 : hold1_q;
    assign out_op2 = (state_q == LECTURA) ? lect_op2 : hold2_q;
    assign out_rs1 = rs1_q;
    assign out_rs2 = rs2_q;
    assign out_tag = tag_q;

    // Next-state logic for the issue/present/hold sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            VACIO: begin
                if (acc) state_d = LECTURA;
            end
            LECTURA, RETENIDO: begin
                if (xfer) state_d = acc ? LECTURA : VACIO;
                else      state_d = RETENIDO;
            end
            default: state_d = VACIO;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= VACIO;
        else     state_q <= state_d;
    end

    // Capture request metadata and issue-cycle write bypass on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            tag_q   <= '0;
            byp1_q  <= '0;
            byp2_q  <= '0;
            bypf1_q <= 1'b0;
            bypf2_q <= 1'b0;
        end else if (acc) begin
            rs1_q   <= in_rs1;
            rs2_q   <= in_rs2;
            tag_q   <= in_tag;
            bypf1_q <= fwd_hit(wb_hab, wb_addr, in_rs1);
            bypf2_q <= fwd_hit(wb_hab, wb_addr, in_rs2);
            if (fwd_hit(wb_hab, wb_addr, in_rs1)) byp1_q <= wb_data;
            if (fwd_hit(wb_hab, wb_addr, in_rs2)) byp2_q <= wb_data;
        end
    end

    // Hold registers: latch on first stall cycle (merging a concurrent write),
    // then keep absorbing writes while stalled. The transfer-cycle write is
    // deliberately ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold1_q <= '0;
            hold2_q <= '0;
        end else if (state_q == LECTURA && !xfer) begin
            hold1_q <= fwd_hit(wb_hab, wb_addr, rs1_q) ? wb_data : lect_op1;
            hold2_q <= fwd_hit(wb_hab, wb_addr, rs2_q) ? wb_data : lect_op2;
        end else if (state_q == RETENIDO && !xfer) begin
            if (fwd_hit(wb_hab, wb_addr, rs1_q)) hold1_q <= wb_data;
            if (fwd_hit(wb_hab, wb_addr, rs2_q)) hold2_q <= wb_data;
        end
    end

endmodule

// File: tb/tb_lectura_operandos.sv
// Directed bench for lectura_operandos with a behavioural 2R/1W register file
// (read-old-on-collision, 1-cycle read latency).
module tb_lectura_operandos;

    localparam int TAG_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [4:0]       in_rs1, in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             rf_hab_r1, rf_hab_r2;
    logic [4:0]       rf_addr_r1, rf_addr_r2;
    logic [31:0]      rf_data_r1, rf_data_r2;
    logic             wb_hab;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             out_valid, out_ready;
    logic [31:0]      out_op1, out_op2;
    logic [4:0]       out_rs1, out_rs2;
    logic [TAG_W-1:0] out_tag;

    logic        rf_clr;
    logic [31:0] mem [32];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    lectura_operandos #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .rf_hab_r1(rf_hab_r1), .rf_addr_r1(rf_addr_r1), .rf_data_r1(rf_data_r1),
        .rf_hab_r2(rf_hab_r2), .rf_addr_r2(rf_addr_r2), .rf_data_r2(rf_data_r2),
        .wb_hab(wb_hab), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_tag(out_tag)
    );

    // Register file model: no x0 guard, reads return the pre-write value.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            rf_data_r1 <= 32'd0;
            rf_data_r2 <= 32'd0;
        end else begin
            if (rf_hab_r1) rf_data_r1 <= mem[rf_addr_r1];
            if (rf_hab_r2) rf_data_r2 <= mem[rf_addr_r2];
            if (wb_hab) mem[wb_addr] <= wb_data;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        wb_hab   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_hab = 1'b1; wb_addr = a; wb_data = d; in_valid = 1'b0;
        @(negedge clk);
        wb_hab = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready);
        else passes++;
        checks++;
        if (rf_hab_r1 !== 1'b0 || rf_hab_r2 !== 1'b0)
            $display("FAIL rst_rf_hab got=%b%b exp=00", rf_hab_r1, rf_hab_r2);
        else passes++;
        @(negedge clk);
        rst = 1'b0; idle();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_state got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        else passes++;
        checks++;
        if (out_op1 !== 32'd0 || out_op2 !== 32'd0 || out_rs1 !== 5'd0 || out_rs2 !== 5'd0 || out_tag !== '0)
            $display("FAIL rst_outputs got op1=%h op2=%h rs1=%0d rs2=%0d tag=%h exp all 0",
                     out_op1, out_op2, out_rs1, out_rs2, out_tag);
        else passes++;
    endtask

    task automatic test_basic();
        wr(5'd5, 32'h1111_1111);
        wr(5'd6, 32'h2222_2222);
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_tag = 32'h100; out_ready = 1'b1;
        #1;
        checks++;
        if (rf_hab_r1 !== 1'b1 || rf_hab_r2 !== 1'b1 || rf_addr_r1 !== 5'd5 || rf_addr_r2 !== 5'd6)
            $display("FAIL basic_issue got hab=%b%b a1=%0d a2=%0d exp hab=11 a1=5 a2=6",
                     rf_hab_r1, rf_hab_r2, rf_addr_r1, rf_addr_r2);
        else passes++;
        @(negedge clk);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_op1 !== 32'h1111_1111 || out_op2 !== 32'h2222_2222 || out_tag !== 32'h100)
            $display("FAIL basic_out got vld=%b op1=%h op2=%h tag=%h exp vld=1 op1=11111111 op2=22222222 tag=100",
                     out_valid, out_op1, out_op2, out_tag);
        else passes++;
        checks++;
        if (out_rs1 !== 5'd5 || out_rs2 !== 5'd6)
            $display("FAIL basic_rs got rs1=%0d rs2=%0d exp 5 6", out_rs1, out_rs2);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_drain got vld=%b exp=0", out_valid);
        else passes++;
    endtask

    task automatic test_bypass();
        wr(5'd8, 32'h0000_8888);
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd8; in_tag = 32'h7;
        wb_hab = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_op1 !== 32'hDEAD_BEEF)
            $display("FAIL bypass_op1 got vld=%b op1=%h exp vld=1 op1=deadbeef", out_valid, out_op1);
        else passes++;
        checks++;
        if (out_op2 !== 32'h0000_8888) $display("FAIL bypass_op2 got=%h exp=00008888", out_op2);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_stall_write();
        wr(5'd9, 32'h5);
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd9; in_tag = 32'h9; out_ready = 1'b0;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_op2 !== 32'h5)
            $display("FAIL stall_c1 got vld=%b rdy=%b op2=%h exp vld=1 rdy=0 op2=5", out_valid, in_ready, out_op2);
        else passes++;
        @(negedge clk);
        wb_hab = 1'b1; wb_addr = 5'd9; wb_data = 32'hA;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_op2 !== 32'h5 || rf_hab_r2 !== 1'b0)
            $display("FAIL stall_c2 got vld=%b op2=%h hab=%b exp vld=1 op2=5 hab=0", out_valid, out_op2, rf_hab_r2);
        else passes++;
        @(negedge clk);
        wb_hab = 1'b0;
        checks++;
        if (out_op2 !== 32'hA) $display("FAIL stall_c3 got op2=%h exp=a", out_op2);
        else passes++;
        @(negedge clk);
        out_ready = 1'b1; wb_hab = 1'b1; wb_addr = 5'd9; wb_data = 32'hB;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_op2 !== 32'hA || in_ready !== 1'b1)
            $display("FAIL stall_release got vld=%b op2=%h rdy=%b exp vld=1 op2=a rdy=1", out_valid, out_op2, in_ready);
        else passes++;
        @(negedge clk);
        idle();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL stall_drain got vld=%b exp=0", out_valid);
        else passes++;
    endtask

    task automatic test_stall_merge();
        wr(5'd10, 32'h10);
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd10; in_rs2 = 5'd6; in_tag = 32'hA; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; wb_hab = 1'b1; wb_addr = 5'd10; wb_data = 32'h77;
        checks++;
        if (out_op1 !== 32'h10) $display("FAIL merge_c1 got op1=%h exp=10", out_op1);
        else passes++;
        @(negedge clk);
        wb_hab = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op1 !== 32'h77 || out_op2 !== 32'h2222_2222)
            $display("FAIL merge_hold got vld=%b op1=%h op2=%h exp vld=1 op1=77 op2=22222222",
                     out_valid, out_op1, out_op2);
        else passes++;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2;
        wr(5'd1, 32'hA1);
        wr(5'd2, 32'hA2);
        wr(5'd3, 32'hA3);
        wr(5'd4, 32'hA4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                in_valid = 1'b1; in_rs1 = 5'(i + 1); in_rs2 = 5'(4 - i); in_tag = 32'h200 + 32'(i);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 4) begin
                checks++;
                if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready);
                else passes++;
            end
            if (i > 0) begin
                exp1 = 32'hA0 + 32'(i);
                exp2 = 32'hA0 + 32'(5 - i);
                checks++;
                if (out_valid !== 1'b1 || out_op1 !== exp1 || out_op2 !== exp2 || out_tag !== 32'h200 + 32'(i - 1))
                    $display("FAIL b2b_out[%0d] got vld=%b op1=%h op2=%h tag=%h exp vld=1 op1=%h op2=%h tag=%h",
                             i - 1, out_valid, out_op1, out_op2, out_tag, exp1, exp2, 32'h200 + 32'(i - 1));
                else passes++;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain got vld=%b exp=0", out_valid);
        else passes++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd5; in_tag = 32'h0;
        wb_hab = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; out_ready = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (out_op1 !== 32'd0 || out_op2 !== 32'h1111_1111)
            $display("FAIL x0_fwd got op1=%h op2=%h exp op1=0 op2=11111111", out_op1, out_op2);
        else passes++;
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd6; in_rs2 = 5'd0;
        @(negedge clk);
        idle();
        checks++;
        if (out_op1 !== 32'h2222_2222 || out_op2 !== 32'd0)
            $display("FAIL x0_read got op1=%h op2=%h exp op1=22222222 op2=0", out_op1, out_op2);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_tag = 32'h3AB; out_ready = 1'b0;
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_op1 !== 32'h1111_1111)
            $display("FAIL rmid_held got vld=%b op1=%h exp vld=1 op1=11111111", out_valid, out_op1);
        else passes++;
        rst = 1'b1; in_valid = 1'b1; in_rs1 = 5'd1;
        @(negedge clk);
        rst = 1'b0; idle(); out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_op1 !== 32'd0 || out_op2 !== 32'd0 || out_tag !== '0 || out_rs1 !== 5'd0)
            $display("FAIL rmid_cleared got vld=%b op1=%h op2=%h tag=%h rs1=%0d exp all 0",
                     out_valid, out_op1, out_op2, out_tag, out_rs1);
        else passes++;
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd6; in_rs2 = 5'd5; in_tag = 32'h55;
        @(negedge clk);
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_op1 !== 32'h2222_2222 || out_op2 !== 32'h1111_1111 || out_tag !== 32'h55)
            $display("FAIL rmid_after got vld=%b op1=%h op2=%h tag=%h exp vld=1 op1=22222222 op2=11111111 tag=55",
                     out_valid, out_op1, out_op2, out_tag);
        else passes++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rf_clr = 1'b1;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        wb_hab = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rf_clr = 1'b0;
        test_reset();
        test_basic();
        test_bypass();
        test_stall_write();
        test_stall_merge();
        test_back_to_back();
        test_x0();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
